// File: rtl/spi_adc_responder_pkg.sv
// spi_adc_responder_pkg: shared ADC-link frame format and responder state encoding
package spi_adc_responder_pkg;
    localparam int FRAME_BITS = 16;
    localparam int DATA_W = 12;
    localparam int SYNC_STAGES = 2;
    typedef enum logic [1:0] {IDLE, ACTIVE, WAIT_CS} state_t;
endpackage

// File: rtl/spi_adc_responder_if.sv
// spi_adc_responder_if: four-wire SPI bus between the master and the ADC responder
interface spi_adc_responder_if;
    logic sck;
    logic cs;
    logic mosi;
    logic miso;
    modport master (output sck, cs, mosi, input miso);
    modport slave (input sck, cs, mosi, output miso);
endinterface

// File: rtl/spi_adc_responder_sync_edge_det.sv
// sync_edge_det: N-stage synchronizer with registered rise/fall pulses from the last two stages
module sync_edge_det import spi_adc_responder_pkg::*; #(
    parameter int N = SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [N:0] s;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            s <= '0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s <= {s[N-1:0], d};
            rise <= s[N-1] & ~s[N];
            fall <= ~s[N-1] & s[N];
        end
    assign q = s[N-1];
endmodule

// File: rtl/spi_adc_responder.sv
// spi_adc_responder: mode-0 SPI converter stand-in serving a held sample and capturing the command word
module spi_adc_responder import spi_adc_responder_pkg::*; #(
    parameter int FRAME_BITS = spi_adc_responder_pkg::FRAME_BITS,
    parameter int DATA_W = spi_adc_responder_pkg::DATA_W,
    parameter int SYNC_STAGES = spi_adc_responder_pkg::SYNC_STAGES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    spi_adc_responder_if.slave    spi,
    input  logic [DATA_W-1:0]     sample_in,
    input  logic                  sample_wr,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_err,
    output logic                  busy
);
    localparam int CW = $clog2(FRAME_BITS + 1);
    state_t state, state_n;
    logic sck_rise, sck_fall, sck_lvl_unused;
    logic cs_q, cs_rise, cs_fall;
    logic mosi_q, mosi_rise_unused, mosi_fall_unused;
    logic [DATA_W-1:0] hold, hold_n;
    logic [FRAME_BITS-1:0] tx, tx_init, rx;
    logic [CW-1:0] cnt;
    logic overrun, miso_q, full;
    sync_edge_det #(.N(SYNC_STAGES)) u_sck (
        .clk(clk), .rst_n(rst_n), .d(spi.sck), .q(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall)
    );
    sync_edge_det #(.N(SYNC_STAGES)) u_cs (
        .clk(clk), .rst_n(rst_n), .d(spi.cs), .q(cs_q), .rise(cs_rise), .fall(cs_fall)
    );
    sync_edge_det #(.N(SYNC_STAGES)) u_mosi (
        .clk(clk), .rst_n(rst_n), .d(spi.mosi), .q(mosi_q), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );
    // a write landing on the cs-fall cycle is served by the frame it starts
    assign hold_n = sample_wr ? sample_in : hold;
    assign tx_init = FRAME_BITS'(hold_n);
    assign full = cnt == CW'(FRAME_BITS);
    assign busy = state == ACTIVE;
    assign spi.miso = miso_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= WAIT_CS;
        else state <= state_n;
    always_comb begin
        state_n = state;
        state_n = (state == WAIT_CS && cs_q) ? IDLE :
                  (state == IDLE && cs_fall) ? ACTIVE :
                  (state == ACTIVE && cs_rise) ? IDLE : state;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            hold <= '0;
            tx <= '0;
            rx <= '0;
            cnt <= '0;
            overrun <= 1'b0;
            miso_q <= 1'b0;
            rx_data <= '0;
            rx_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            hold <= hold_n;
            rx_valid <= 1'b0;
            frame_err <= 1'b0;
            if (state == IDLE && cs_fall) begin
                tx <= tx_init;
                rx <= '0;
                cnt <= '0;
                overrun <= 1'b0;
                miso_q <= tx_init[FRAME_BITS-1];
            end else if (state == ACTIVE && cs_rise) begin
                miso_q <= 1'b0;
                rx_valid <= full && !overrun;
                frame_err <= !(full && !overrun);
                if (full && !overrun) rx_data <= rx;
            end else if (state == ACTIVE) begin
                if (sck_rise) begin
                    rx <= {rx[FRAME_BITS-2:0], mosi_q};
                    if (full) overrun <= 1'b1;
                    else cnt <= cnt + CW'(1);
                end
                if (sck_fall) begin
                    tx <= tx << 1;
                    miso_q <= tx[FRAME_BITS-2];
                end
            end
        end
endmodule

// File: tb/tb_spi_adc_responder.sv
// tb_spi_adc_responder: directed mode-0 frames with a pulse scoreboard checked by a separate monitor
module tb_spi_adc_responder;
    import spi_adc_responder_pkg::*;
    typedef struct packed {
        logic err;
        logic [FRAME_BITS-1:0] data;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sample_wr = 1'b0;
    logic [DATA_W-1:0] sample_in = '0;
    logic [FRAME_BITS-1:0] rx_data;
    logic rx_valid, frame_err, busy;
    int checks = 0;
    int failures = 0;
    exp_t sb[$];
    spi_adc_responder_if spi();
    spi_adc_responder dut (
        .clk(clk), .rst_n(rst_n), .spi(spi), .sample_in(sample_in), .sample_wr(sample_wr),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    always @(negedge clk)
        if (rst_n && (rx_valid || frame_err)) begin
            exp_t e;
            if (sb.size() == 0) chk("unexpected_pulse", {30'b0, rx_valid, frame_err}, 32'h0);
            else begin
                e = sb.pop_front();
                chk("pulse_kind", {30'b0, rx_valid, frame_err}, e.err ? 32'h1 : 32'h2);
                chk("pulse_rx_data", {16'b0, rx_data}, {16'b0, e.data});
            end
        end
    task automatic write(input logic [DATA_W-1:0] v);
        sample_in = v;
        sample_wr = 1'b1;
        @(negedge clk);
        sample_wr = 1'b0;
    endtask
    task automatic cs_fall(input bit wr, input logic [DATA_W-1:0] v);
        spi.cs = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (wr && k == 3) begin
                sample_in = v;
                sample_wr = 1'b1;
            end
            if (k == 4) sample_wr = 1'b0;
        end
    endtask
    task automatic cs_rise();
        repeat (5) @(negedge clk);
        spi.cs = 1'b1;
        repeat (12) @(negedge clk);
    endtask
    task automatic bits(input logic [FRAME_BITS-1:0] w, input int n, input int wr_at,
                        input logic [DATA_W-1:0] v, output logic [31:0] got);
        got = '0;
        for (int i = 0; i < n; i++) begin
            spi.mosi = i < FRAME_BITS ? w[FRAME_BITS-1-i] : 1'b0;
            repeat (5) @(negedge clk);
            got = {got[30:0], spi.miso};
            spi.sck = 1'b1;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                sample_wr = (i == wr_at && k == 0);
                if (i == wr_at) sample_in = v;
            end
            spi.sck = 1'b0;
        end
    endtask
    task automatic good_frame(input logic [FRAME_BITS-1:0] w, input logic [FRAME_BITS-1:0] exp_miso,
                              input bit wr_fall, input logic [DATA_W-1:0] v, input int wr_at, input string name);
        logic [31:0] got;
        cs_fall(wr_fall, v);
        bits(w, FRAME_BITS, wr_at, v, got);
        chk({name, "_miso"}, got, {16'b0, exp_miso});
        chk({name, "_busy"}, {31'b0, busy}, 32'h1);
        sb.push_back('{err: 1'b0, data: w});
        cs_rise();
        chk({name, "_idle"}, {30'b0, busy, spi.miso}, 32'h0);
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
    initial begin
        logic [31:0] got;
        spi.sck = 1'b0;
        spi.cs = 1'b1;
        spi.mosi = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs", {12'b0, rx_data, rx_valid, frame_err, busy, spi.miso}, 32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        write(12'hA5C);
        good_frame(16'h6000, 16'h0A5C, 1'b0, '0, -1, "basic");
        write(12'hFFF);
        good_frame(16'h1234, 16'h0FFF, 1'b0, '0, -1, "ones");
        write(12'h000);
        good_frame(16'hFFFF, 16'h0000, 1'b0, '0, -1, "zeros");
        cs_fall(1'b0, '0);
        bits(16'hABCD, 9, -1, '0, got);
        sb.push_back('{err: 1'b1, data: 16'hFFFF});
        cs_rise();
        write(12'h3C3);
        good_frame(16'hA55A, 16'h03C3, 1'b0, '0, -1, "after_short");
        cs_fall(1'b0, '0);
        bits(16'h1111, 17, -1, '0, got);
        chk("overrun_miso", {16'b0, got[16:1]}, 32'h03C3);
        chk("overrun_bit17", {31'b0, got[0]}, 32'h0);
        sb.push_back('{err: 1'b1, data: 16'hA55A});
        cs_rise();
        write(12'h456);
        good_frame(16'h0F0F, 16'h0456, 1'b0, 12'h123, 5, "mid_wr");
        good_frame(16'h8001, 16'h0123, 1'b0, '0, -1, "after_mid_wr");
        good_frame(16'h4242, 16'h07E1, 1'b1, 12'h7E1, -1, "wr_on_fall");
        cs_fall(1'b0, '0);
        bits(16'hFFFF, 7, -1, '0, got);
        rst_n = 1'b0;
        #1;
        chk("midreset_outs", {12'b0, rx_data, rx_valid, frame_err, busy, spi.miso}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bits(16'hFFFF, 16, -1, '0, got);
        chk("wait_cs_miso", got, 32'h0);
        chk("wait_cs_busy", {31'b0, busy}, 32'h0);
        cs_rise();
        chk("post_reset_rx_data", {16'b0, rx_data}, 32'h0);
        write(12'h5A5);
        good_frame(16'hC3C3, 16'h05A5, 1'b0, '0, -1, "post_reset");
        repeat (20) @(negedge clk);
        chk("sb_empty", sb.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_adc_responder.md
# spi_adc_responder

SPI responder that plays the converter side of the 12-bit ADC link: it answers the team's SPI master state machine on `sck`/`cs`/`mosi`/`miso`. It serves a host-loaded 12-bit sample MSB-first on `miso` and captures the master's `mosi` command word. It sits in bench/loopback builds and in the FPGA top as an ADC stand-in, driven by the prescaled system clock.

## Interface
- `FRAME_BITS`, 16: SCK cycles per frame.
- `DATA_W`, 12: sample width, right-aligned in the frame; leading `FRAME_BITS-DATA_W` bits are 0.
- `SYNC_STAGES`, 2: synchronizer depth on `sck`, `cs`, `mosi`.
- `clk  in  1`: single system clock; all logic on rising edge.
- `rst_n  in  1`: reset, asynchronous and active-low.
- `sck  in  1`: SPI clock from master, mode 0 (CPOL=0, CPHA=0), asynchronous to `clk`.
- `cs  in  1`: chip select, active-low.
- `mosi  in  1`: master data out.
- `miso  out  1`: responder data out.
- `sample_in  in  DATA_W`: sample to serve.
- `sample_wr  in  1`: one-cycle strobe loading `sample_in` into the holding register.
- `rx_data  out  FRAME_BITS`: last complete command word, MSB-first order.
- `rx_valid  out  1`: one-cycle pulse when `rx_data` updates.
- `frame_err  out  1`: one-cycle pulse on a malformed frame.
- `busy  out  1`: high while state is ACTIVE.

## Operation
- Inputs pass through `SYNC_STAGES` flops; edges are detected on the last two synchronized stages.
- Holding register `hold` (DATA_W) is written on `sample_wr`; reset value 0.
- States: IDLE, ACTIVE, WAIT_CS.
  - IDLE: on `cs` falling edge, load shift-out register `{zeros, hold}`, clear bit counter, clear `rx` shift register, drive `miso` = frame MSB (0), go ACTIVE.
  - ACTIVE: on `sck` rising edge, shift `mosi` into `rx` and increment counter (saturates at `FRAME_BITS`). On `sck` falling edge, shift out the next bit; after the last bit, `miso` = 0.
  - ACTIVE, on `cs` rising edge:
    - if counter == `FRAME_BITS`, update `rx_data` and pulse `rx_valid`;
    - otherwise pulse `frame_err`, leaving `rx_data` unchanged;
    - then go IDLE.
  - Extra `sck` rising edges beyond `FRAME_BITS` are counted as overrun (sticky flag). The frame ends with `frame_err` and no `rx_valid`.
  - WAIT_CS: entered after reset if `cs` is low; returns to IDLE on the first synchronized `cs` high. A frame never starts without a seen high-to-low edge.
- `miso` is 0 whenever not ACTIVE.
- If `sample_wr` and the `cs` fall edge occur in the same cycle, the new `sample_in` is served (write-through).
- `sample_wr` during ACTIVE updates `hold` only; the current frame is unaffected.
- Simultaneous `sck` edge and `cs` rise in one cycle: the `cs` rise wins and the `sck` edge is ignored.

## Timing
- Reset values: `miso`=0, `rx_data`=0, `rx_valid`=0, `frame_err`=0, `busy`=0, `hold`=0, state IDLE/WAIT_CS per synchronized `cs`.
- Edge-detect latency is `SYNC_STAGES`+1 `clk` cycles from a pin transition.
- `miso` updates `SYNC_STAGES`+2 cycles after the `sck` falling pin edge.
- Requirement: `clk` ≥ 8× `sck` frequency, and the master's `cs`-fall-to-first-`sck`-rise delay ≥ 4 `clk` periods.
- `rx_valid`/`frame_err` assert `SYNC_STAGES`+2 cycles after the `cs` rising pin edge, for exactly 1 cycle, mutually exclusive.
- `rx_data` is stable from `rx_valid` until the next `rx_valid`.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous). The aborted frame produces no pulse.

## Structure
- Shared package: state encoding typedef (IDLE/ACTIVE/WAIT_CS) and default constants `FRAME_BITS`, `DATA_W`, `SYNC_STAGES`, reused by the SPI master for the same frame format.
- One sub-module: `sync_edge_det` (N-stage synchronizer plus rise/fall pulses), instanced three times. Its `mosi` instance uses level output only.

## Test plan
- Load `sample_in`=0xA5C via `sample_wr`, run a 16-bit mode-0 frame at `clk`/10 with `mosi`=0x6000 -> `miso` bits 0000_1010_0101_1100, `rx_valid` pulse, `rx_data`=0x6000.
- Loop the team's SPI master to this block with `hold`=0xFFF, then 0x000 -> master `o_DATA` matches each, with DATA_VALID per frame.
- Raise `cs` after 9 `sck` cycles -> `frame_err` pulse, no `rx_valid`, `rx_data` keeps its previous value, next full frame is correct.
- Send 17 `sck` cycles -> `frame_err`; `miso`=0 for bit 17.
- `sample_wr` 0x123 mid-frame while serving 0x456 -> current frame serves 0x456, next frame serves 0x123. `sample_wr` on the `cs`-fall cycle -> new value served.
- Assert `rst_n` low at bit 7 with `cs` held low -> outputs at reset values, no frame accepted until `cs` goes high and then falls again.
